// File: rtl/irq_controller.sv
// irq_controller
// Memory-mapped priority interrupt controller for the CS0 IO region.
// Eight asynchronous interrupt lines are synchronised, latched into PEND,
// gated by MASK and presented one at a time to the CPU as a one-hot request.
// The CPU acknowledges with irq_ack and ends service with a write to STAT (EOI).
//
// Ports:
//   clk        - system bus clock
//   rst_n      - asynchronous active-low reset
//   irq_in     - raw external interrupt lines (asynchronous, active-high)
//   CS         - chip select, high when the CPU addresses this block
//   adresse    - register select: 0 PEND, 1 MASK, 2 MODE, 3 STAT
//   write      - write strobe, register write when CS & write at posedge clk
//   DATAout    - CPU write data
//   DATAin     - read data (combinational), zero when CS is low
//   irq_onehot - one-hot request to the CPU, zero when nothing is presented
//   irq_ack    - single-cycle CPU acknowledge of the presented request
//
// SYNC_STAGES must be at least 2.

module irq_controller #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RST_MODE    = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  irq_in,
    input  logic        CS,
    input  logic [1:0]  adresse,
    input  logic        write,
    input  logic [15:0] DATAout,
    output logic [15:0] DATAin,
    output logic [7:0]  irq_onehot,
    input  logic        irq_ack
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t     state_q, state_d;

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] prev_q;
    logic [7:0] pend_q;
    logic [7:0] mask_q;
    logic [7:0] mode_q;
    logic       in_service_q;
    logic [2:0] vector_q;

    logic [7:0] synced;
    logic [7:0] set_bits;
    logic [7:0] clr_bits;
    logic [7:0] eligible;
    logic [7:0] top_onehot;
    logic [2:0] top_index;
    logic       wr_en;
    logic       eoi;
    logic       take_ack;

    // Only the low byte of write data is meaningful for this block.
    logic       unused_data_hi;
    assign unused_data_hi = ^DATAout[15:8];

    // Input synchroniser chain plus a delayed copy of the synced value,
    // used to spot rising edges for the edge-triggered lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= synced;
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Edge-mode lines latch on a rising edge; level-mode lines latch every
    // cycle they are high.
    assign set_bits = (synced & ~prev_q & mode_q) | (synced & ~mode_q);

    assign wr_en    = CS & write;
    assign eoi      = wr_en && (adresse == 2'd3);
    assign eligible = pend_q & mask_q;

    // Isolate the lowest set bit: bit 0 has the highest priority.
    assign top_onehot = eligible & (~eligible + 8'd1);

    always_comb begin
        top_index = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) begin
                top_index = 3'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and request output. The request in REQ follows the eligible
    // set every cycle, so a higher-priority arrival preempts before the ack.
    always_comb begin
        state_d    = state_q;
        take_ack   = 1'b0;
        irq_onehot = '0;
        case (state_q)
            IDLE: begin
                if (eligible != '0) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                irq_onehot = top_onehot;
                if (eligible == '0) begin
                    state_d = IDLE;
                end else if (irq_ack) begin
                    take_ack = 1'b1;
                    state_d  = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending clears: software write-1-to-clear plus the acknowledged bit
    // for edge-mode lines. Level lines are left to be re-set by the line.
    always_comb begin
        clr_bits = '0;
        if (wr_en && (adresse == 2'd0)) begin
            clr_bits = DATAout[7:0];
        end
        if (take_ack) begin
            clr_bits = clr_bits | (top_onehot & mode_q);
        end
    end

    // Register file and service bookkeeping. Sets win over clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= '0;
            mask_q       <= '0;
            mode_q       <= RST_MODE;
            in_service_q <= 1'b0;
            vector_q     <= '0;
        end else begin
            pend_q <= (pend_q & ~clr_bits) | set_bits;
            if (wr_en && (adresse == 2'd1)) begin
                mask_q <= DATAout[7:0];
            end
            if (wr_en && (adresse == 2'd2)) begin
                mode_q <= DATAout[7:0];
            end
            if (take_ack) begin
                in_service_q <= 1'b1;
                vector_q     <= top_index;
            end else if ((state_q == SERVICE) && eoi) begin
                in_service_q <= 1'b0;
                vector_q     <= '0;
            end
        end
    end

    // Read mux.
    always_comb begin
        DATAin = '0;
        if (CS) begin
            case (adresse)
                2'd0:    DATAin = {8'h00, pend_q};
                2'd1:    DATAin = {8'h00, mask_q};
                2'd2:    DATAin = {8'h00, mode_q};
                default: DATAin = {in_service_q, (state_q == REQ), 11'h000, vector_q};
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller
// Self-checking bench for irq_controller: directed scenarios with constant
// expectations, then randomized traffic compared against a behavioural model.

module tb_irq_controller;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_in;
    logic        cs;
    logic [1:0]  adresse;
    logic        wr_strobe;
    logic [15:0] dout;
    logic [15:0] din;
    logic [7:0]  irq_onehot;
    logic        irq_ack;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model of the controller.
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    logic [7:0] m_mode;
    logic       m_requesting;
    logic       m_in_service;
    logic [2:0] m_vec;
    logic [7:0] hist [$];

    always #5 clk = ~clk;

    irq_controller #(
        .SYNC_STAGES(SYNC),
        .RST_MODE   (8'hFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .CS        (cs),
        .adresse   (adresse),
        .write     (wr_strobe),
        .DATAout   (dout),
        .DATAin    (din),
        .irq_onehot(irq_onehot),
        .irq_ack   (irq_ack)
    );

    function automatic logic [7:0] lowest_bit(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 8'd1 << i;
        end
        return 8'h00;
    endfunction

    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    function automatic logic [15:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {8'h00, m_pend};
            2'd1:    return {8'h00, m_mask};
            2'd2:    return {8'h00, m_mode};
            default: return {m_in_service, m_requesting, 11'h000, m_vec};
        endcase
    endfunction

    function automatic logic [7:0] model_onehot();
        return m_requesting ? lowest_bit(m_pend & m_mask) : 8'h00;
    endfunction

    task automatic model_reset();
        m_pend       = 8'h00;
        m_mask       = 8'h00;
        m_mode       = 8'hFF;
        m_requesting = 1'b0;
        m_in_service = 1'b0;
        m_vec        = 3'd0;
        hist.delete();
        for (int k = 0; k <= SYNC; k++) hist.push_back(8'h00);
    endtask

    // hist[0] is the newest sample of irq_in; the line value the controller
    // acts on lags the raw line by SYNC samples.
    task automatic model_edge();
        logic [7:0] syn, prv, set_b, clr_b, e;
        logic       wr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        syn   = hist[SYNC-1];
        prv   = hist[SYNC];
        set_b = (syn & ~prv & m_mode) | (syn & ~m_mode);
        clr_b = 8'h00;
        e     = m_pend & m_mask;
        wr    = cs && wr_strobe;
        if (m_requesting) begin
            if (e == 8'h00) begin
                m_requesting = 1'b0;
            end else if (irq_ack) begin
                m_vec        = lowest_index(e);
                m_requesting = 1'b0;
                m_in_service = 1'b1;
                if (m_mode[m_vec]) clr_b = lowest_bit(e);
            end
        end else if (m_in_service) begin
            if (wr && adresse == 2'd3) begin
                m_in_service = 1'b0;
                m_vec        = 3'd0;
            end
        end else if (e != 8'h00) begin
            m_requesting = 1'b1;
        end
        if (wr) begin
            case (adresse)
                2'd0:    clr_b = clr_b | dout[7:0];
                2'd1:    m_mask = dout[7:0];
                2'd2:    m_mode = dout[7:0];
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clr_b) | set_b;
        hist.push_front(irq_in);
        void'(hist.pop_back());
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        wr_strobe = 1'b0;
        irq_ack   = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        cs        = 1'b1;
        adresse   = a;
        dout      = d;
        wr_strobe = 1'b1;
        tick();
    endtask

    task automatic set_read(input logic [1:0] a);
        cs      = 1'b1;
        adresse = a;
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        irq_in    = 8'h00;
        cs        = 1'b0;
        adresse   = 2'd0;
        wr_strobe = 1'b0;
        dout      = 16'h0000;
        irq_ack   = 1'b0;
        #1;
        model_reset();
        ticks(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        set_read(2);
        n_checks++; if (din !== 16'h00FF) begin n_fails++; $display("[TB] FAIL reset_mode: got %h expected %h", din, 16'h00FF); end
        set_read(1);
        n_checks++; if (din !== 16'h0000) begin n_fails++; $display("[TB] FAIL reset_mask: got %h expected %h", din, 16'h0000); end
        // Drive the controller into SERVICE, then reset asynchronously.
        bus_write(1, 16'h0001);
        irq_in = 8'h01;
        ticks(3);
        irq_in = 8'h00;
        tick();
        irq_ack = 1'b1;
        tick();
        set_read(3);
        n_checks++; if (din !== 16'h8000) begin n_fails++; $display("[TB] FAIL pre_reset_stat: got %h expected %h", din, 16'h8000); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (irq_onehot !== 8'h00) begin n_fails++; $display("[TB] FAIL async_onehot: got %h expected %h", irq_onehot, 8'h00); end
        set_read(3);
        n_checks++; if (din !== 16'h0000) begin n_fails++; $display("[TB] FAIL async_stat: got %h expected %h", din, 16'h0000); end
        set_read(2);
        n_checks++; if (din !== 16'h00FF) begin n_fails++; $display("[TB] FAIL async_mode: got %h expected %h", din, 16'h00FF); end
        set_read(1);
        n_checks++; if (din !== 16'h0000) begin n_fails++; $display("[TB] FAIL async_mask: got %h expected %h", din, 16'h0000); end
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_edge();
        do_reset();
        bus_write(1, 16'h0004);
        irq_in = 8'h04;
        ticks(2);
        set_read(0);
        n_checks++; if (din !== 16'h0000) begin n_fails++; $display("[TB] FAIL single_pend_e2: got %h expected %h", din, 16'h0000); end
        tick();
        irq_in = 8'h00;
        set_read(0);
        n_checks++; if (din !== 16'h0004) begin n_fails++; $display("[TB] FAIL single_pend_e3: got %h expected %h", din, 16'h0004); end
        n_checks++; if (irq_onehot !== 8'h00) begin n_fails++; $display("[TB] FAIL single_onehot_e3: got %h expected %h", irq_onehot, 8'h00); end
        tick();
        n_checks++; if (irq_onehot !== 8'h04) begin n_fails++; $display("[TB] FAIL single_onehot_e4: got %h expected %h", irq_onehot, 8'h04); end
        irq_ack = 1'b1;
        tick();
        set_read(0);
        n_checks++; if (din !== 16'h0000) begin n_fails++; $display("[TB] FAIL single_pend_ack: got %h expected %h", din, 16'h0000); end
        set_read(3);
        n_checks++; if (din !== 16'h8002) begin n_fails++; $display("[TB] FAIL single_stat_ack: got %h expected %h", din, 16'h8002); end
        bus_write(3, 16'h0000);
        set_read(3);
        n_checks++; if (din !== 16'h0000) begin n_fails++; $display("[TB] FAIL single_stat_eoi: got %h expected %h", din, 16'h0000); end
        tick();
        n_checks++; if (irq_onehot !== 8'h00) begin n_fails++; $display("[TB] FAIL single_idle: got %h expected %h", irq_onehot, 8'h00); end
    endtask

    task automatic test_priority();
        do_reset();
        bus_write(1, 16'h00FF);
        irq_in = 8'h20;
        ticks(4);
        n_checks++; if (irq_onehot !== 8'h20) begin n_fails++; $display("[TB] FAIL prio_first: got %h expected %h", irq_onehot, 8'h20); end
        irq_in = 8'h22;
        ticks(3);
        n_checks++; if (irq_onehot !== 8'h02) begin n_fails++; $display("[TB] FAIL prio_preempt: got %h expected %h", irq_onehot, 8'h02); end
        irq_ack = 1'b1;
        tick();
        set_read(3);
        n_checks++; if (din !== 16'h8001) begin n_fails++; $display("[TB] FAIL prio_stat: got %h expected %h", din, 16'h8001); end
        set_read(0);
        n_checks++; if (din !== 16'h0020) begin n_fails++; $display("[TB] FAIL prio_pend: got %h expected %h", din, 16'h0020); end
        irq_ack = 1'b1;
        tick();
        n_checks++; if (irq_onehot !== 8'h00) begin n_fails++; $display("[TB] FAIL prio_no_nest: got %h expected %h", irq_onehot, 8'h00); end
        bus_write(3, 16'h0000);
        tick();
        n_checks++; if (irq_onehot !== 8'h20) begin n_fails++; $display("[TB] FAIL prio_after_eoi: got %h expected %h", irq_onehot, 8'h20); end
    endtask

    task automatic test_masking();
        do_reset();
        irq_in = 8'h10;
        ticks(3);
        irq_in = 8'h00;
        tick();
        n_checks++; if (irq_onehot !== 8'h00) begin n_fails++; $display("[TB] FAIL mask_blocked: got %h expected %h", irq_onehot, 8'h00); end
        set_read(0);
        n_checks++; if (din !== 16'h0010) begin n_fails++; $display("[TB] FAIL mask_pend: got %h expected %h", din, 16'h0010); end
        bus_write(1, 16'h0010);
        tick();
        n_checks++; if (irq_onehot !== 8'h10) begin n_fails++; $display("[TB] FAIL mask_enable: got %h expected %h", irq_onehot, 8'h10); end
        bus_write(1, 16'h0000);
        tick();
        n_checks++; if (irq_onehot !== 8'h00) begin n_fails++; $display("[TB] FAIL mask_drop: got %h expected %h", irq_onehot, 8'h00); end
        set_read(3);
        n_checks++; if (din !== 16'h0000) begin n_fails++; $display("[TB] FAIL mask_idle_stat: got %h expected %h", din, 16'h0000); end
    endtask

    task automatic test_level_mode();
        do_reset();
        bus_write(2, 16'h00FE);
        bus_write(1, 16'h0001);
        irq_in = 8'h01;
        ticks(4);
        n_checks++; if (irq_onehot !== 8'h01) begin n_fails++; $display("[TB] FAIL level_req: got %h expected %h", irq_onehot, 8'h01); end
        irq_ack = 1'b1;
        tick();
        set_read(3);
        n_checks++; if (din !== 16'h8000) begin n_fails++; $display("[TB] FAIL level_stat: got %h expected %h", din, 16'h8000); end
        bus_write(3, 16'h0000);
        tick();
        n_checks++; if (irq_onehot !== 8'h01) begin n_fails++; $display("[TB] FAIL level_reassert: got %h expected %h", irq_onehot, 8'h01); end
        irq_ack = 1'b1;
        tick();
        irq_in = 8'h00;
        ticks(3);
        bus_write(0, 16'h0001);
        bus_write(3, 16'h0000);
        ticks(2);
        n_checks++; if (irq_onehot !== 8'h00) begin n_fails++; $display("[TB] FAIL level_quiet: got %h expected %h", irq_onehot, 8'h00); end
        set_read(0);
        n_checks++; if (din !== 16'h0000) begin n_fails++; $display("[TB] FAIL level_pend: got %h expected %h", din, 16'h0000); end
    endtask

    task automatic test_collision();
        do_reset();
        irq_in = 8'h08;
        ticks(3);
        irq_in = 8'h00;
        ticks(3);
        set_read(0);
        n_checks++; if (din !== 16'h0008) begin n_fails++; $display("[TB] FAIL coll_first: got %h expected %h", din, 16'h0008); end
        irq_in = 8'h08;
        ticks(2);
        bus_write(0, 16'h0008);
        set_read(0);
        n_checks++; if (din !== 16'h0008) begin n_fails++; $display("[TB] FAIL coll_set_wins: got %h expected %h", din, 16'h0008); end
        bus_write(0, 16'h0008);
        set_read(0);
        n_checks++; if (din !== 16'h0000) begin n_fails++; $display("[TB] FAIL coll_w1c: got %h expected %h", din, 16'h0000); end
    endtask

    task automatic test_random();
        int         b;
        int         r;
        logic [1:0] a;
        logic       c;
        logic [7:0] exp8;
        logic [15:0] exp16;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            if ($urandom_range(0, 2) == 0) begin
                b = $urandom_range(0, 7);
                irq_in[b] = ~irq_in[b];
            end
            r         = $urandom_range(0, 19);
            cs        = 1'b1;
            adresse   = 2'($urandom_range(0, 3));
            dout      = 16'($urandom);
            wr_strobe = 1'b0;
            if (r == 0) begin
                adresse = 2'd1; wr_strobe = 1'b1;
            end else if (r == 1) begin
                adresse = 2'd0; wr_strobe = 1'b1;
            end else if (r == 2) begin
                adresse = 2'd2; wr_strobe = 1'b1;
            end else if (r <= 5) begin
                adresse = 2'd3; wr_strobe = 1'b1;
            end else if (r <= 7) begin
                cs = 1'b0; wr_strobe = 1'b1;
            end
            irq_ack = ($urandom_range(0, 2) == 0);
            tick();
            exp8 = model_onehot();
            n_checks++; if (irq_onehot !== exp8) begin n_fails++; $display("[TB] FAIL rand_onehot cyc %0d: got %h expected %h", cyc, irq_onehot, exp8); end
            a = 2'($urandom_range(0, 3));
            c = ($urandom_range(0, 5) != 0);
            cs      = c;
            adresse = a;
            #1;
            exp16 = c ? model_read(a) : 16'h0000;
            n_checks++; if (din !== exp16) begin n_fails++; $display("[TB] FAIL rand_read cyc %0d addr %0d cs %0b: got %h expected %h", cyc, a, c, din, exp16); end
        end
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_priority();
        test_masking();
        test_level_mode();
        test_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule
